// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake between the memory/IO front end and the SRAM bus sequencer.
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Bus-cycle sequencer for an external async 1Mx16 SRAM: one request at a time,
// registered strobes with programmable wait states and a write-to-read turnaround.
module sram_access_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    sram_access_ctrl_if.slave bus,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic              UB_N,
    output logic              LB_N,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_write,
    input  logic [DATA_W-1:0] Data_read,
    output logic              drive_en
);

    localparam int MAX_RW   = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int MAX_WAIT = (MAX_RW > TURN) ? MAX_RW : TURN;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, RD, RDONE, WS, WP, WH, TA} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;
    logic              drive_en_q, drive_en_d;
    logic              accept;
    logic              active_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        accept  = bus.req_valid && ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    be_d    = bus.req_be;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (bus.req_we) begin
                        state_d = WS;
                    end else begin
                        state_d = RD;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            RD: begin
                // Data is sampled on the edge that ends the last OE_N-low cycle.
                if (cnt_q == '0) begin
                    rdata_d = Data_read;
                    state_d = RDONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RDONE: state_d = IDLE;
            WS: begin
                state_d = WP;
                cnt_d   = WR_LOAD;
            end
            WP: begin
                if (cnt_q == '0) state_d = WH;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            WH: begin
                if (TURN == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = TA;
                    cnt_d   = TA_LOAD;
                end
            end
            TA: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state and registered so the pins never glitch.
    always_comb begin
        active_d    = (state_d == RD) || (state_d == WS) || (state_d == WP) || (state_d == WH);
        ce_n_d      = !active_d;
        oe_n_d      = (state_d != RD);
        we_n_d      = (state_d != WP);
        ub_n_d      = !(active_d && be_d[1]);
        lb_n_d      = !(active_d && be_d[0]);
        drive_en_d  = (state_d == WS) || (state_d == WP) || (state_d == WH);
        rsp_valid_d = (state_d == RDONE) || (state_d == WH);
        ready_d     = (state_d == IDLE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            lb_n_q      <= 1'b1;
            drive_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            drive_en_q  <= drive_en_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign CE_N          = ce_n_q;
    assign OE_N          = oe_n_q;
    assign WE_N          = we_n_q;
    assign UB_N          = ub_n_q;
    assign LB_N          = lb_n_q;
    assign ADDR          = addr_q;
    assign Data_write    = wdata_q;
    assign drive_en      = drive_en_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomized bench for sram_access_ctrl against a per-transaction timeline model.
module tb_sram_access_ctrl;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 16;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam int TURN    = 1;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              CE_N, OE_N, WE_N, UB_N, LB_N, drive_en;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_write;
    logic [DATA_W-1:0] Data_read;

    always #5 Clk = ~Clk;

    sram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .TURN(TURN)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus),
        .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
        .ADDR(ADDR), .Data_write(Data_write), .Data_read(Data_read),
        .drive_en(drive_en)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Model: phase 0=idle, 1=read, 2=write; k counts cycles since the accept edge.
    int                phase;
    int                k;
    int                n_acc;
    bit                acc_ev;
    logic              ready_e;
    logic [1:0]        be_e;
    logic [ADDR_W-1:0] addr_e;
    logic [DATA_W-1:0] wdata_e;
    logic [DATA_W-1:0] rdata_e;

    task automatic model_reset();
        phase   = 0;
        k       = 0;
        acc_ev  = 0;
        ready_e = 1'b0;
        be_e    = 2'b00;
        addr_e  = '0;
        wdata_e = '0;
        rdata_e = '0;
    endtask

    task automatic model_step();
        acc_ev = 0;
        if (phase == 0) begin
            if (ready_e && bus.req_valid) begin
                phase   = bus.req_we ? 2 : 1;
                k       = 1;
                be_e    = bus.req_be;
                addr_e  = bus.req_addr;
                wdata_e = bus.req_wdata;
                acc_ev  = 1;
                n_acc++;
            end
        end else begin
            if (phase == 1 && k == RD_WAIT) rdata_e = Data_read;
            k++;
            if (phase == 1 && k == RD_WAIT + 2)        phase = 0;
            if (phase == 2 && k == WR_WAIT + TURN + 3) phase = 0;
        end
        ready_e = (phase == 0);
    endtask

    task automatic check_outputs();
        logic ce, oe, we, ub, lb, de, rv;
        ce = 1; oe = 1; we = 1; ub = 1; lb = 1; de = 0; rv = 0;
        if (phase == 1 && k <= RD_WAIT) begin
            ce = 0; oe = 0; ub = ~be_e[1]; lb = ~be_e[0];
        end
        if (phase == 1 && k == RD_WAIT + 1) rv = 1;
        if (phase == 2 && k <= WR_WAIT + 2) begin
            ce = 0; de = 1; ub = ~be_e[1]; lb = ~be_e[0];
            if (k >= 2 && k <= WR_WAIT + 1) we = 0;
            if (k == WR_WAIT + 2) rv = 1;
        end
        check_eq("strobes", {CE_N, OE_N, WE_N, UB_N, LB_N, drive_en}, {ce, oe, we, ub, lb, de});
        check_eq("rsp_valid", bus.rsp_valid, rv);
        check_eq("req_ready", bus.req_ready, ready_e);
        check_eq("rsp_rdata", bus.rsp_rdata, rdata_e);
        check_eq("addr", ADDR, addr_e);
        check_eq("data_write", Data_write, wdata_e);
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic wait_idle(input string tag);
        int c;
        c = 0;
        while (phase != 0 && c < 50) begin
            tick();
            c++;
        end
        check_eq(tag, (phase == 0), 1'b1);
    endtask

    initial begin
        int rsp_cnt;
        int n0;
        int cyc;

        Reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        Data_read     = '0;
        n_acc         = 0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_outputs();
        Reset = 1'b1;
        tick();
        check_eq("ready_after_rst", bus.req_ready, 1'b1);

        // Directed read at 0x00123, full word.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_be = 2'b11;
        bus.req_addr = 20'h00123; Data_read = 16'hBEEF;
        tick();
        bus.req_valid = 1'b0;
        check_eq("rd_c1_ce_oe", {CE_N, OE_N}, 2'b00);
        tick();
        tick();
        check_eq("rd_c3_rsp", bus.rsp_valid, 1'b1);
        check_eq("rd_c3_data", bus.rsp_rdata, 16'hBEEF);
        tick();
        check_eq("rd_c4_ready", bus.req_ready, 1'b1);

        // Directed upper-byte write; inputs change right after accept.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 2'b10;
        bus.req_addr = 20'h0FFFF; bus.req_wdata = 16'h1234;
        tick();
        bus.req_valid = 1'b0; bus.req_addr = 20'hABCDE; bus.req_wdata = 16'h5555;
        check_eq("wr_c1_data", Data_write, 16'h1234);
        check_eq("wr_c1_bytes", {UB_N, LB_N, WE_N}, 3'b011);
        tick();
        check_eq("wr_c2_we", WE_N, 1'b0);
        tick();
        tick();
        check_eq("wr_c4_rsp", bus.rsp_valid, 1'b1);
        check_eq("wr_c4_addr", ADDR, 20'h0FFFF);
        tick();
        check_eq("wr_c5_ta", {CE_N, drive_en, bus.req_ready}, 3'b100);
        tick();
        check_eq("wr_c6_ready", bus.req_ready, 1'b1);
        check_eq("wr_keeps_rdata", bus.rsp_rdata, 16'hBEEF);

        // Lower-byte read.
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_be = 2'b01; Data_read = 16'h0F0F;
        tick();
        bus.req_valid = 1'b0;
        check_eq("rd_lo_bytes", {UB_N, LB_N}, 2'b10);
        wait_idle("rd_lo_done");
        tick();

        // Back-to-back alternating writes and reads with req_valid held.
        rsp_cnt = 0;
        n0 = n_acc;
        cyc = 0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        while (cyc < 400 && (n_acc - n0 < 20 || phase != 0)) begin
            tick();
            if (bus.rsp_valid) rsp_cnt++;
            if (acc_ev) begin
                bus.req_we = ~bus.req_we;
                if (n_acc - n0 >= 20) bus.req_valid = 1'b0;
            end
            bus.req_be    = 2'($urandom_range(0, 3));
            bus.req_addr  = 20'($urandom);
            bus.req_wdata = 16'($urandom);
            Data_read     = 16'($urandom);
            cyc++;
        end
        bus.req_valid = 1'b0;
        check_eq("alt_accepts", n_acc - n0, 20);
        check_eq("alt_rsp_count", rsp_cnt, 20);

        // Fully random traffic.
        for (int i = 0; i < 600; i++) begin
            bus.req_valid = ($urandom_range(0, 3) != 0);
            bus.req_we    = 1'($urandom_range(0, 1));
            bus.req_be    = 2'($urandom_range(0, 3));
            bus.req_addr  = 20'($urandom);
            bus.req_wdata = 16'($urandom);
            Data_read     = 16'($urandom);
            tick();
        end
        bus.req_valid = 1'b0;
        wait_idle("rand_done");

        // Reset in the middle of the WE_N-low phase.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_be = 2'b11;
        bus.req_addr = 20'h00042; bus.req_wdata = 16'hCAFE;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check_eq("pre_rst_we", WE_N, 1'b0);
        #2 Reset = 1'b0;
        #1;
        check_eq("rst_abort", {WE_N, CE_N, drive_en, bus.rsp_valid}, 4'b1100);
        model_reset();
        @(negedge Clk);
        check_outputs();
        Reset = 1'b1;
        tick();
        check_eq("rst_rel_ready", bus.req_ready, 1'b1);
        check_eq("rst_rel_rsp", bus.rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
